toggle_arbiter: RTL and testbench

TOGGLE_ARBITER -- requirements
Module: toggle_arbiter

---
 rtl/toggle_arbiter.sv | 114 +++++++++++
 tb/tb_toggle_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/toggle_arbiter.sv
// Round-robin arbiter granting NREQ requesters one toggle per cycle on a shared T flip-flop bank.
// Optional macro TOGGLE_ARB_LOCK_EN adds a per-bit lock input and a per-requester nack output.
module toggle_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IDXW-1:0] idx,
`ifdef TOGGLE_ARB_LOCK_EN
    input  logic [WIDTH-1:0]     lock,
    output logic [NREQ-1:0]      nack,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic [15:0]          toggle_cnt
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   locked;
    logic [NREQ-1:0]   in_range;
    logic [IDXW-1:0]   idx_a [NREQ];
    logic [PW-1:0]     cand, wsel;
    logic              found;
`ifdef TOGGLE_ARB_LOCK_EN
    logic [NREQ-1:0]   nack_q, nack_d;
`endif

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        assign idx_a[g]    = idx[g*IDXW +: IDXW];
        // Indices past the bank still win grants but address no flip-flop.
        assign in_range[g] = (int'(idx_a[g]) < WIDTH);
`ifdef TOGGLE_ARB_LOCK_EN
        assign locked[g]   = in_range[g] & lock[idx_a[g]];
`else
        assign locked[g]   = 1'b0;
`endif
    end

    always_comb begin
        elig    = req & {NREQ{en}} & ~gnt_q & ~locked;
        state_d = IDLE;
        gnt_d   = '0;
        q_d     = q_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        wsel    = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && elig[cand]) begin
                found = 1'b1;
                wsel  = cand;
            end
        end
        if (found) begin
            state_d     = GRANT;
            gnt_d[wsel] = 1'b1;
            cnt_d       = cnt_q + 16'd1;
            ptr_d       = PW'((int'(wsel) + 1) % NREQ);
            if (in_range[wsel]) begin
                q_d[idx_a[wsel]] = ~q_q[idx_a[wsel]];
            end
        end
    end

`ifdef TOGGLE_ARB_LOCK_EN
    assign nack_d = req & {NREQ{en}} & locked;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
`ifdef TOGGLE_ARB_LOCK_EN
            nack_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
`ifdef TOGGLE_ARB_LOCK_EN
            nack_q  <= nack_d;
`endif
        end
    end

    assign gnt        = gnt_q;
    assign q          = q_q;
    assign toggle_cnt = cnt_q;
    assign busy       = (state_q == GRANT);
`ifdef TOGGLE_ARB_LOCK_EN
    assign nack       = nack_q;
`endif

endmodule

// File: tb/tb_toggle_arbiter.sv
// Directed, table-driven bench for toggle_arbiter, plus hand sequences for out-of-range
// indices, counter wrap and reset during an active grant stream.
module tb_toggle_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [11:0] idx = 12'h000;
    logic [3:0]  gnt, gnt2;
    logic [7:0]  q;
    logic [5:0]  q2;
    logic        busy, busy2;
    logic [15:0] cnt, cnt2;
`ifdef TOGGLE_ARB_LOCK_EN
    logic [7:0]  lock  = 8'h00;
    logic [5:0]  lock2 = 6'h00;
    logic [3:0]  nack, nack2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    toggle_arbiter #(.NREQ(4), .WIDTH(8), .IDXW(3)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .idx(idx),
`ifdef TOGGLE_ARB_LOCK_EN
        .lock(lock), .nack(nack),
`endif
        .gnt(gnt), .q(q), .busy(busy), .toggle_cnt(cnt)
    );

    // Narrow bank so that 3-bit indices 6 and 7 fall outside it.
    toggle_arbiter #(.NREQ(4), .WIDTH(6), .IDXW(3)) dut2 (
        .clk(clk), .rst(rst), .en(en), .req(req), .idx(idx),
`ifdef TOGGLE_ARB_LOCK_EN
        .lock(lock2), .nack(nack2),
`endif
        .gnt(gnt2), .q(q2), .busy(busy2), .toggle_cnt(cnt2)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  req;
        logic [11:0] idx;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic [15:0] cnt;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [3:0] rq, input logic [11:0] ix);
        rst = r;
        en  = e;
        req = rq;
        idx = ix;
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [3:0] eg, input logic [7:0] eq,
                              input logic [15:0] ec, input logic eb);
        check({tag, ".gnt"},  32'(gnt),  32'(eg));
        check({tag, ".q"},    32'(q),    32'(eq));
        check({tag, ".cnt"},  32'(cnt),  32'(ec));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
    endtask

    initial begin
        //                rst   en    req      idx      gnt      q      cnt    busy
        vecs.push_back(vec_t'{1'b0, 1'b1, 4'b1111, 12'h000, 4'b0000, 8'h00, 16'd0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 4'b0000, 12'h000, 4'b0000, 8'h00, 16'd0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b0001, 12'h003, 4'b0001, 8'h08, 16'd1, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b0001, 12'h003, 4'b0000, 8'h08, 16'd1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b0000, 12'h003, 4'b0000, 8'h08, 16'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 12'h000, 4'b0000, 8'h00, 16'd0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b1111, 12'h000, 4'b0001, 8'h01, 16'd1, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b1111, 12'h000, 4'b0010, 8'h00, 16'd2, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b1111, 12'h000, 4'b0100, 8'h01, 16'd3, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b1111, 12'h000, 4'b1000, 8'h00, 16'd4, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b1111, 12'h000, 4'b0001, 8'h01, 16'd5, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 4'b1111, 12'h000, 4'b0000, 8'h01, 16'd5, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 4'b1111, 12'h000, 4'b0000, 8'h01, 16'd5, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b1111, 12'h000, 4'b0010, 8'h00, 16'd6, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b0000, 12'h000, 4'b0000, 8'h00, 16'd6, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 12'h000, 4'b0000, 8'h00, 16'd0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b0101, 12'h145, 4'b0001, 8'h20, 16'd1, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b0100, 12'h145, 4'b0100, 8'h00, 16'd2, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b0000, 12'h145, 4'b0000, 8'h00, 16'd2, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 12'h000, 4'b0000, 8'h00, 16'd0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b0011, 12'h011, 4'b0001, 8'h02, 16'd1, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b1, 4'b0000, 12'h011, 4'b0000, 8'h02, 16'd1, 1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].idx);
            check_main($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].cnt, vecs[i].busy);
        end

        // Out-of-range indices on the 6-bit bank: granted and counted, bank untouched.
        drive(1'b0, 1'b1, 4'b0000, 12'h000);
        drive(1'b1, 1'b1, 4'b0001, 12'h007);
        check_main("oor0.w8", 4'b0001, 8'h80, 16'd1, 1'b1);
        check("oor0.w6.gnt", 32'(gnt2), 32'(4'b0001));
        check("oor0.w6.q",   32'(q2),   32'(6'h00));
        check("oor0.w6.cnt", 32'(cnt2), 32'd1);
        drive(1'b1, 1'b1, 4'b0010, 12'h030);
        check_main("oor1.w8", 4'b0010, 8'hC0, 16'd2, 1'b1);
        check("oor1.w6.gnt", 32'(gnt2), 32'(4'b0010));
        check("oor1.w6.q",   32'(q2),   32'(6'h00));
        check("oor1.w6.cnt", 32'(cnt2), 32'd2);

        // Counter wrap: two requesters alternate, one grant per cycle.
        drive(1'b0, 1'b1, 4'b0000, 12'h000);
        for (int n = 0; n < 65535; n++) begin
            drive(1'b1, 1'b1, 4'b0011, 12'h000);
        end
        check_main("wrap.pre", 4'b0001, 8'h01, 16'hFFFF, 1'b1);
        drive(1'b1, 1'b1, 4'b0011, 12'h000);
        check_main("wrap.post", 4'b0010, 8'h00, 16'h0000, 1'b1);

        // Reset in the middle of a grant stream, then priority restarts at requester 0.
        drive(1'b1, 1'b1, 4'b1111, 12'h000);
        check_main("mid.grant", 4'b0100, 8'h01, 16'd1, 1'b1);
        drive(1'b0, 1'b1, 4'b1111, 12'h000);
        check_main("mid.rst", 4'b0000, 8'h00, 16'd0, 1'b0);
        drive(1'b1, 1'b1, 4'b1111, 12'h000);
        check_main("mid.release", 4'b0001, 8'h01, 16'd1, 1'b1);

`ifdef TOGGLE_ARB_LOCK_EN
        drive(1'b0, 1'b1, 4'b0000, 12'h000);
        check("lock.rst.nack", 32'(nack), 32'(4'b0000));
        lock = 8'h04;
        drive(1'b1, 1'b1, 4'b0010, 12'h010);
        check("lock.on.nack", 32'(nack), 32'(4'b0010));
        check_main("lock.on", 4'b0000, 8'h00, 16'd0, 1'b0);
        lock = 8'h00;
        drive(1'b1, 1'b1, 4'b0010, 12'h010);
        check("lock.off.nack", 32'(nack), 32'(4'b0000));
        check_main("lock.off", 4'b0010, 8'h04, 16'd1, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
